uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter between NUM_REQ byte sources using round-robin arbitration.
- Sits between client logic (debug, status, loopback) and the transmitter's i_TX_DV/i_TX_Byte inputs.
- Issues one byte at a time and waits for the transmitter's done pulse before it re-arbitrates.
- A watchdog recovers if the done pulse never arrives.

---
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_arbiter_if
// Brief  : Requester / transmitter handshake bundle for uart_tx_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_Req_Valid;
    logic [8*NUM_REQ-1:0] i_Req_Data;
    logic [NUM_REQ-1:0]   o_Req_Ready;
    logic                 o_TX_DV;
    logic [7:0]           o_TX_Byte;
    logic                 i_TX_Done;
    logic [NUM_REQ-1:0]   o_Grant;
    logic                 o_Busy;
    logic                 o_Timeout;

    modport master (
        input  i_Req_Valid, i_Req_Data, i_TX_Done,
        output o_Req_Ready, o_TX_DV, o_TX_Byte, o_Grant, o_Busy, o_Timeout
    );

    modport slave (
        output i_Req_Valid, i_Req_Data, i_TX_Done,
        input  o_Req_Ready, o_TX_DV, o_TX_Byte, o_Grant, o_Busy, o_Timeout
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_arbiter
// Brief  : Round-robin sharing of one UART transmitter with a done watchdog.
//          Define UART_ARB_TAG_EN to prefix each byte with tag {4'hA, grant}.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = 1024
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    uart_tx_arbiter_if.master    bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
`ifdef UART_ARB_TAG_EN
        TAG_ISSUE = 3'd3,
        TAG_WAIT  = 3'd4,
`endif
        WAIT_DONE = 3'd2
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   gidx_q;
    logic [CNT_W-1:0]   wdog_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] ready_q;
    logic [7:0]         tx_byte_q;
    logic               dv_q;
    logic               timeout_q;
`ifdef UART_ARB_TAG_EN
    logic [7:0]         data_q;
`endif

    logic               w_found;
    logic [PTR_W-1:0]   w_sel;
    logic [PTR_W:0]     w_idx;
    logic [NUM_REQ-1:0] w_onehot;
    logic [7:0]         w_sel_byte;
    logic               w_wdog_expired;

    // First valid requester at or after ptr, wrapping past NUM_REQ-1.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (w_idx >= (PTR_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!w_found && bus.i_Req_Valid[w_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[PTR_W-1:0];
            end
        end
    end

    assign w_onehot       = NUM_REQ'(1) << w_sel;
    assign w_sel_byte     = bus.i_Req_Data[{w_sel, 3'b000} +: 8];
    assign w_wdog_expired = (wdog_q == CNT_W'(TIMEOUT_CLKS - 1));

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            wdog_q    <= '0;
            grant_q   <= '0;
            ready_q   <= '0;
            tx_byte_q <= '0;
            dv_q      <= 1'b0;
            timeout_q <= 1'b0;
`ifdef UART_ARB_TAG_EN
            data_q    <= '0;
`endif
        end else begin
            dv_q    <= 1'b0;
            ready_q <= '0;
            case (state_q)
                IDLE: begin
                    wdog_q <= '0;
                    if (w_found) begin
                        grant_q <= w_onehot;
                        gidx_q  <= w_sel;
                        dv_q    <= 1'b1;
`ifdef UART_ARB_TAG_EN
                        data_q    <= w_sel_byte;
                        tx_byte_q <= {4'hA, 4'(w_sel)};
                        state_q   <= TAG_ISSUE;
`else
                        tx_byte_q <= w_sel_byte;
                        ready_q   <= w_onehot;
                        state_q   <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    ptr_q   <= (gidx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
                    wdog_q  <= '0;
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.i_TX_Done || w_wdog_expired) begin
                        // A missing done still counts the byte as sent.
                        timeout_q <= timeout_q | ~bus.i_TX_Done;
                        grant_q   <= '0;
                        wdog_q    <= '0;
                        state_q   <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
`ifdef UART_ARB_TAG_EN
                TAG_ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= TAG_WAIT;
                end
                TAG_WAIT: begin
                    if (bus.i_TX_Done) begin
                        wdog_q    <= '0;
                        dv_q      <= 1'b1;
                        ready_q   <= grant_q;
                        tx_byte_q <= data_q;
                        state_q   <= ISSUE;
                    end else if (w_wdog_expired) begin
                        timeout_q <= 1'b1;
                        grant_q   <= '0;
                        wdog_q    <= '0;
                        state_q   <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
`endif
                default: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_Req_Ready = ready_q;
    assign bus.o_TX_DV     = dv_q;
    assign bus.o_TX_Byte   = tx_byte_q;
    assign bus.o_Grant     = grant_q;
    assign bus.o_Busy      = (state_q != IDLE);
    assign bus.o_Timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_tx_arbiter
// Brief  : Directed self-checking bench for uart_tx_arbiter (4 requesters,
//          16-clock watchdog); follows UART_ARB_TAG_EN when defined.
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int NUM_REQ      = 4;
    localparam int TIMEOUT_CLKS = 16;

    logic clk;
    logic rst_l;
    int   n_checks;
    int   n_errors;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) dut (
        .i_Clock (clk),
        .i_Rst_L (rst_l),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int k, input logic [7:0] v);
        bus.i_Req_Data[8*k +: 8] = v;
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        tick();
        tick();
        rst_l = 1'b1;
    endtask

    task automatic pulse_done();
        bus.i_TX_Done = 1'b1;
        tick();
        bus.i_TX_Done = 1'b0;
    endtask

    task automatic wait_dv(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (bus.o_TX_DV) return;
        end
        check_eq("dv_wait_expired", 32'd0, 32'd1);
    endtask

    // One complete grant: (tag phase), data strobe with ready, wait, done.
    task automatic xfer(input int g, input logic [7:0] b, input bit drop, input int hold);
        int n;
        wait_dv(n);
        check_eq("dv_latency", 32'(n), 32'd1);
`ifdef UART_ARB_TAG_EN
        check_eq("tag_byte", 32'(bus.o_TX_Byte), 32'({4'hA, 4'(g)}));
        check_eq("tag_ready", 32'(bus.o_Req_Ready), 32'd0);
        check_eq("tag_grant", 32'(bus.o_Grant), 32'(1 << g));
        tick();
        check_eq("tag_dv_pulse", 32'(bus.o_TX_DV), 32'd0);
        pulse_done();
`endif
        check_eq("dv", 32'(bus.o_TX_DV), 32'd1);
        check_eq("byte", 32'(bus.o_TX_Byte), 32'(b));
        check_eq("grant", 32'(bus.o_Grant), 32'(1 << g));
        check_eq("ready", 32'(bus.o_Req_Ready), 32'(1 << g));
        if (drop) bus.i_Req_Valid[g] = 1'b0;
        tick();
        check_eq("dv_pulse", 32'(bus.o_TX_DV), 32'd0);
        check_eq("ready_pulse", 32'(bus.o_Req_Ready), 32'd0);
        check_eq("grant_hold", 32'(bus.o_Grant), 32'(1 << g));
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq("busy_wait", 32'(bus.o_Busy), 32'd1);
        end
        pulse_done();
        check_eq("busy_done", 32'(bus.o_Busy), 32'd0);
        check_eq("grant_idle", 32'(bus.o_Grant), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_grant"}, 32'(bus.o_Grant), 32'd0);
        check_eq({tag, "_dv"}, 32'(bus.o_TX_DV), 32'd0);
        check_eq({tag, "_ready"}, 32'(bus.o_Req_Ready), 32'd0);
        check_eq({tag, "_byte"}, 32'(bus.o_TX_Byte), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.o_Busy), 32'd0);
        check_eq({tag, "_timeout"}, 32'(bus.o_Timeout), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        n_checks         = 0;
        n_errors         = 0;
        rst_l            = 1'b0;
        bus.i_Req_Valid  = '0;
        bus.i_Req_Data   = '0;
        bus.i_TX_Done    = 1'b0;
        do_reset();
        check_all_zero("reset");

        // Single request from requester 2, done held off a few cycles.
        set_data(2, 8'h5A);
        bus.i_Req_Valid = 4'b0100;
        xfer(2, 8'h5A, 1'b1, 3);

        // Contention from reset: 0,1,2,3,0 with all valids held.
        do_reset();
        set_data(0, 8'h10);
        set_data(1, 8'h21);
        set_data(2, 8'h32);
        set_data(3, 8'h43);
        bus.i_Req_Valid = 4'b1111;
        xfer(0, 8'h10, 1'b0, 0);
        xfer(1, 8'h21, 1'b0, 0);
        xfer(2, 8'h32, 1'b0, 0);
        xfer(3, 8'h43, 1'b0, 0);
        xfer(0, 8'h10, 1'b0, 0);
        bus.i_Req_Valid = '0;

        // Wrap: grant 3, then only 1 and 3 valid -> 1 then 3.
        set_data(3, 8'h9C);
        bus.i_Req_Valid = 4'b1000;
        xfer(3, 8'h9C, 1'b1, 0);
        set_data(1, 8'h5E);
        bus.i_Req_Valid = 4'b1010;
        xfer(1, 8'h5E, 1'b1, 0);
        xfer(3, 8'h9C, 1'b1, 0);

        // Watchdog: no done ever arrives.
        set_data(0, 8'hC3);
        bus.i_Req_Valid = 4'b0001;
        wait_dv(n);
`ifdef UART_ARB_TAG_EN
        check_eq("wd_tag_byte", 32'(bus.o_TX_Byte), 32'hA0);
        check_eq("wd_ready", 32'(bus.o_Req_Ready), 32'd0);
`else
        check_eq("wd_byte", 32'(bus.o_TX_Byte), 32'hC3);
        check_eq("wd_ready", 32'(bus.o_Req_Ready), 32'b0001);
`endif
        bus.i_Req_Valid = '0;
        for (int i = 0; i < TIMEOUT_CLKS; i++) tick();
        check_eq("wd_not_yet", 32'(bus.o_Timeout), 32'd0);
        check_eq("wd_busy_before", 32'(bus.o_Busy), 32'd1);
        tick();
        check_eq("wd_timeout", 32'(bus.o_Timeout), 32'd1);
        check_eq("wd_idle", 32'(bus.o_Busy), 32'd0);
        check_eq("wd_grant", 32'(bus.o_Grant), 32'd0);
        set_data(2, 8'h77);
        bus.i_Req_Valid = 4'b0100;
        xfer(2, 8'h77, 1'b1, 0);
        check_eq("wd_sticky", 32'(bus.o_Timeout), 32'd1);

        // Mid-operation reset: in-flight grant to 1 moves ptr past 0.
        set_data(1, 8'h4E);
        bus.i_Req_Valid = 4'b0010;
        wait_dv(n);
        tick();
        check_eq("mid_busy", 32'(bus.o_Busy), 32'd1);
        rst_l = 1'b0;
        set_data(0, 8'h11);
        set_data(2, 8'h22);
        bus.i_Req_Valid = 4'b0101;
        tick();
        check_all_zero("mid_reset");
        rst_l = 1'b1;
        xfer(0, 8'h11, 1'b1, 0);
        xfer(2, 8'h22, 1'b1, 0);

        // Requester 1 sends 8'h33 (tag 8'hA1 first when tagging is built in).
        set_data(1, 8'h33);
        bus.i_Req_Valid = 4'b0010;
        xfer(1, 8'h33, 1'b1, 0);

        // A stray done in IDLE must not disturb the next grant.
        pulse_done();
        check_eq("stray_done_idle", 32'(bus.o_Busy), 32'd0);
        set_data(3, 8'hE7);
        bus.i_Req_Valid = 4'b1000;
        xfer(3, 8'hE7, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
